sensor_xfer_sched: RTL and testbench

SENSOR_XFER_SCHED -- requirements
Module: sensor_xfer_sched

---
 rtl/sensor_pkg.sv | 26 ++
 rtl/sensor_xfer_sched_period_tick.sv | 38 +++
 rtl/sensor_xfer_sched.sv | 146 ++++++++++++++
 tb/tb_sensor_xfer_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the periodic sensor-read / UART transfer scheduler.
package sensor_pkg;

  localparam int unsigned PERIOD_CYC_DEF  = 10_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned SPI_W           = 16;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [3:0] {
    IDLE,
    SPI_START,
    SPI_WAIT,
    TX_HI,
    TX_HI_WAIT,
    TX_LO,
    TX_LO_WAIT,
    CPU_TX,
    CPU_WAIT
  } xfer_state_e;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_xfer_sched_period_tick.sv
// Sampling-period counter with a single-entry pending tick and overrun detect.
module period_tick
  import sensor_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic take,
  output logic tick_c,
  output logic tick_pend,
  output logic overrun_c
);

  localparam int unsigned CW = cnt_w(PERIOD_CYC);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt;

  assign tick_c    = en && (cnt == LAST);
  assign overrun_c = tick_c && tick_pend;

  // Disabling clears both the phase and any unserviced tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      tick_pend <= 1'b0;
    end else begin
      if (!en || tick_c) cnt <= '0;
      else               cnt <= cnt + CW'(1);

      if (!en || take)   tick_pend <= 1'b0;
      else if (tick_c)   tick_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/sensor_xfer_sched.sv
// Periodic SPI sensor read, forwarded as two UART bytes, sharing the UART with CPU bytes.
module sensor_xfer_sched
  import sensor_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              spi_start,
  input  logic              spi_done,
  input  logic [SPI_W-1:0]  spi_data,
  output logic              uart_send,
  output logic [BYTE_W-1:0] uart_byte,
  input  logic              uart_busy,
  input  logic              cpu_req,
  input  logic [BYTE_W-1:0] cpu_byte,
  output logic              cpu_gnt,
  output logic [SPI_W-1:0]  sample,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int unsigned TW = cnt_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  xfer_state_e       state, state_nx;
  logic              first_q;
  logic [TW-1:0]     tmo_cnt;
  logic              tick_c, tick_pend, overrun_c, sensor_req_c, take_c;
  logic              spi_start_nx, uart_send_nx, cpu_gnt_nx;
  logic [BYTE_W-1:0] uart_byte_nx;
  logic              sample_ld_c, timeout_c;

  // A tick in the current cycle counts as pending so it beats a simultaneous CPU request.
  assign sensor_req_c = tick_pend || tick_c;
  assign take_c       = (state == IDLE) && sensor_req_c;

  period_tick #(.PERIOD_CYC(PERIOD_CYC)) u_period_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .take      (take_c),
    .tick_c    (tick_c),
    .tick_pend (tick_pend),
    .overrun_c (overrun_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The *_WAIT states skip uart_busy on their first cycle while the UART picks up the byte.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sensor_req_c)              state_nx = SPI_START;
        else if (cpu_req && !uart_busy) state_nx = CPU_TX;
      end
      SPI_START:  state_nx = SPI_WAIT;
      SPI_WAIT: begin
        if (spi_done)                  state_nx = TX_HI;
        else if (tmo_cnt == TMO_LAST)  state_nx = IDLE;
      end
      TX_HI:      if (!uart_busy)             state_nx = TX_HI_WAIT;
      TX_HI_WAIT: if (!first_q && !uart_busy) state_nx = TX_LO;
      TX_LO:      if (!uart_busy)             state_nx = TX_LO_WAIT;
      TX_LO_WAIT: if (!first_q && !uart_busy) state_nx = IDLE;
      CPU_TX:     state_nx = CPU_WAIT;
      CPU_WAIT:   if (!first_q && !uart_busy) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Next values of the registered pulses; each fires on the transition it announces.
  always_comb begin
    spi_start_nx = 1'b0;
    uart_send_nx = 1'b0;
    cpu_gnt_nx   = 1'b0;
    uart_byte_nx = uart_byte;
    sample_ld_c  = 1'b0;
    timeout_c    = 1'b0;
    case (state)
      IDLE: begin
        if (sensor_req_c) begin
          spi_start_nx = 1'b1;
        end else if (cpu_req && !uart_busy) begin
          uart_send_nx = 1'b1;
          cpu_gnt_nx   = 1'b1;
          uart_byte_nx = cpu_byte;
        end
      end
      SPI_WAIT: begin
        if (spi_done)                 sample_ld_c = 1'b1;
        else if (tmo_cnt == TMO_LAST) timeout_c   = 1'b1;
      end
      TX_HI: begin
        if (!uart_busy) begin
          uart_send_nx = 1'b1;
          uart_byte_nx = sample[15:8];
        end
      end
      TX_LO: begin
        if (!uart_busy) begin
          uart_send_nx = 1'b1;
          uart_byte_nx = sample[7:0];
        end
      end
      default: ;
    endcase
  end

  // Output, timeout and sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q      <= 1'b0;
      tmo_cnt      <= '0;
      spi_start    <= 1'b0;
      uart_send    <= 1'b0;
      cpu_gnt      <= 1'b0;
      uart_byte    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      first_q   <= (state_nx != state);
      tmo_cnt   <= (state == SPI_WAIT) ? tmo_cnt + TW'(1) : '0;
      spi_start <= spi_start_nx;
      uart_send <= uart_send_nx;
      cpu_gnt   <= cpu_gnt_nx;
      uart_byte <= uart_byte_nx;
      if (sample_ld_c) begin
        sample       <= spi_data;
        sample_valid <= 1'b1;
      end
      if (timeout_c) timeout_err <= 1'b1;
      if (overrun_c) overrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_xfer_sched.sv
// Directed bench for sensor_xfer_sched with small SPI/UART/CPU models driven on the falling edge.
`timescale 1ns/1ps
module tb_sensor_xfer_sched;

  localparam int unsigned PER = 100;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_data = '0;
  logic        uart_busy = 1'b0;
  logic        cpu_req = 1'b0;
  logic [7:0]  cpu_byte = '0;
  logic        spi_start, uart_send, cpu_gnt, sample_valid, timeout_err, overrun_err;
  logic [7:0]  uart_byte;
  logic [15:0] sample;

  sensor_xfer_sched #(.PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .spi_start(spi_start), .spi_done(spi_done), .spi_data(spi_data),
    .uart_send(uart_send), .uart_byte(uart_byte), .uart_busy(uart_busy),
    .cpu_req(cpu_req), .cpu_byte(cpu_byte), .cpu_gnt(cpu_gnt),
    .sample(sample), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment configuration (written only by the test sequence)
  logic [15:0] spi_word  = '0;
  int          spi_delay = 0;
  int          busy_len  = 0;
  bit          busy_hold = 1'b0;
  int          cpu_posts = 0;

  // Environment state and logs (written only by the environment)
  int          cyc = 0, spi_starts = 0, start_cyc = 0, prev_start_cyc = 0;
  int          spi_cnt = 0, busy_cnt = 0, cpu_served = 0, excl_bad = 0;
  logic [8:0]  sent_q[$];

  always @(negedge clk) begin
    cyc++;
    if (spi_start) begin
      spi_starts++;
      prev_start_cyc = start_cyc;
      start_cyc      = cyc;
    end
    if (uart_send) sent_q.push_back({cpu_gnt, uart_byte});
    if ((spi_start && (uart_send || cpu_gnt)) || (cpu_gnt && !uart_send)) excl_bad++;
    if (cpu_gnt) cpu_served++;
    cpu_req = (cpu_posts != cpu_served);
    spi_done = 1'b0;
    if (spi_start) spi_cnt = spi_delay;
    else if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        spi_done = 1'b1;
        spi_data = spi_word;
      end
    end
    if (busy_hold) uart_busy = 1'b1;
    else if (uart_send && busy_len > 0) begin
      busy_cnt  = busy_len;
      uart_busy = 1'b1;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      uart_busy = (busy_cnt > 0);
    end
  end

  typedef struct {
    logic [15:0] data;
    int          delay;
    int          busy;
    logic [15:0] exp_sample;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    int base = spi_starts;
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      if (spi_starts != base) seen = 1'b1;
    end
    check({name, " spi_start seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_sends(input int target, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      if (sent_q.size() >= target) seen = 1'b1;
    end
    check({name, " uart bytes seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " spi_start"},    32'(spi_start),    32'd0);
    check({tag, " uart_send"},    32'(uart_send),    32'd0);
    check({tag, " uart_byte"},    32'(uart_byte),    32'd0);
    check({tag, " cpu_gnt"},      32'(cpu_gnt),      32'd0);
    check({tag, " sample"},       32'(sample),       32'd0);
    check({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, " timeout_err"},  32'(timeout_err),  32'd0);
    check({tag, " overrun_err"},  32'(overrun_err),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, starts_base;

    vecs[0] = '{16'hA55A,  5, 3, 16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h0001,  1, 0, 16'h0001, 8'h00, 8'h01};
    vecs[2] = '{16'hFFFF, 10, 7, 16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h1234, 16, 1, 16'h1234, 8'h12, 8'h34};

    // Reset state
    step(3);
    check_all_zero("reset");
    rst = 1'b1;
    en  = 1'b1;

    // Normal sensor transactions on consecutive ticks
    for (int i = 0; i < 4; i++) begin
      spi_word  = vecs[i].data;
      spi_delay = vecs[i].delay;
      busy_len  = vecs[i].busy;
      base      = sent_q.size();
      wait_start($sformatf("vec%0d", i));
      if (i == 1) check("tick period", 32'(start_cyc - prev_start_cyc), 32'(PER));
      wait_sends(base + 2, $sformatf("vec%0d", i));
      check($sformatf("vec%0d sample", i), 32'(sample), 32'(vecs[i].exp_sample));
      check($sformatf("vec%0d sample_valid", i), 32'(sample_valid), 32'd1);
      check($sformatf("vec%0d hi byte", i), 32'(sent_q[base]), {24'd0, vecs[i].exp_hi});
      check($sformatf("vec%0d lo byte", i), 32'(sent_q[base + 1]), {24'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'd0);
    end

    // SPI never answers: timeout after TMO waiting cycles, no UART traffic
    spi_delay = 0;
    busy_len  = 2;
    base      = sent_q.size();
    wait_start("tmo");
    step(TMO);
    check("tmo flag before limit", 32'(timeout_err), 32'd0);
    step(1);
    check("tmo flag at limit", 32'(timeout_err), 32'd1);
    spi_word  = 16'h0F0F;
    spi_delay = 3;
    step(20);
    check("tmo no uart traffic", 32'(sent_q.size()), 32'(base));
    check("tmo sample kept", 32'(sample), 32'h1234);
    wait_start("after tmo");
    wait_sends(base + 2, "after tmo");
    check("after tmo sample", 32'(sample), 32'h0F0F);

    // CPU request during a sensor transaction waits for the LO byte
    spi_word  = 16'hC381;
    spi_delay = 4;
    busy_len  = 4;
    cpu_byte  = 8'h3C;
    base      = sent_q.size();
    wait_start("cpu wait");
    step(3);
    cpu_posts++;
    wait_sends(base + 3, "cpu wait");
    check("cpu wait hi", 32'(sent_q[base]),     32'h0C3);
    check("cpu wait lo", 32'(sent_q[base + 1]), 32'h081);
    check("cpu wait cpu byte+gnt", 32'(sent_q[base + 2]), 32'h13C);

    // CPU request and tick in the same IDLE cycle: sensor first
    spi_word  = 16'h5AA5;
    spi_delay = 2;
    busy_len  = 1;
    while (cyc < start_cyc + 98) step(1);
    cpu_byte = 8'h77;
    cpu_posts++;
    base = sent_q.size();
    wait_start("same cycle");
    check("same cycle no cpu first", 32'(sent_q.size()), 32'(base));
    check("same cycle tick period", 32'(start_cyc - prev_start_cyc), 32'(PER));
    wait_sends(base + 3, "same cycle");
    check("same cycle hi", 32'(sent_q[base]),     32'h05A);
    check("same cycle lo", 32'(sent_q[base + 1]), 32'h0A5);
    check("same cycle cpu", 32'(sent_q[base + 2]), 32'h177);

    // en falls mid-transaction: it completes, no further ticks
    spi_word  = 16'h1357;
    spi_delay = 3;
    busy_len  = 2;
    base      = sent_q.size();
    wait_start("en drop");
    step(1);
    en = 1'b0;
    starts_base = spi_starts;
    wait_sends(base + 2, "en drop");
    check("en drop hi", 32'(sent_q[base]),     32'h013);
    check("en drop lo", 32'(sent_q[base + 1]), 32'h057);
    step(250);
    check("en drop no new start", 32'(spi_starts), 32'(starts_base));

    // UART held busy across two further ticks: overrun, one extra transaction
    spi_word  = 16'hBEEF;
    busy_hold = 1'b1;
    en        = 1'b1;
    base      = sent_q.size();
    wait_start("overrun");
    starts_base = spi_starts;
    step(150);
    check("overrun not yet", 32'(overrun_err), 32'd0);
    step(80);
    check("overrun flag", 32'(overrun_err), 32'd1);
    check("overrun no send while busy", 32'(sent_q.size()), 32'(base));
    busy_hold = 1'b0;
    step(60);
    check("overrun one extra start", 32'(spi_starts - starts_base), 32'd1);
    check("overrun bytes sent", 32'(sent_q.size()), 32'(base + 4));
    check("overrun extra hi", 32'(sent_q[base + 2]), 32'h0BE);
    check("overrun extra lo", 32'(sent_q[base + 3]), 32'h0EF);

    // Reset during TX_LO_WAIT clears everything at once
    spi_word  = 16'h2468;
    spi_delay = 2;
    busy_len  = 20;
    base      = sent_q.size();
    wait_start("reset mid");
    wait_sends(base + 2, "reset mid");
    step(3);
    rst = 1'b0;
    #1;
    check_all_zero("reset mid");
    step(1);
    rst      = 1'b1;
    busy_len = 2;
    base2    = sent_q.size();
    wait_start("after reset");
    check("after reset no stray send", 32'(sent_q.size()), 32'(base2));
    wait_sends(base2 + 2, "after reset");
    check("after reset sample", 32'(sample), 32'h2468);

    check("pulse exclusivity violations", 32'(excl_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
